palette_encoder: RTL and testbench

//   Reverse of the 16-entry sprite palette lookup: maps a 24-bit RGB pixel to the 4-bit palette index
//   of the nearest entry. Used by the sprite-asset packer path ahead of sprite RAM. Searches entries
//   1..15 over several cycles; entry 0 stays reserved as transparent. Valid/ready on both sides.

---
 rtl/palette_encoder.sv | 159 +++++++++++++++
 tb/tb_palette_encoder.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/palette_encoder.sv
// palette_encoder: maps a 24-bit RGB pixel to the nearest palette index.
// Entries 1..15 are searched LANES at a time; entry 0 is reserved.
module palette_encoder #(
    parameter int          LANES           = 1,
    parameter logic [23:0] TRANSPARENT_KEY = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pal_we,
    input  logic [3:0]  i_pal_addr,
    input  logic [23:0] i_pal_data,
    output logic        o_pal_err,
    input  logic        i_valid,
    input  logic [23:0] i_rgb,
    output logic        o_ready,
    output logic        o_valid,
    output logic [3:0]  o_index,
    output logic [9:0]  o_dist,
    input  logic        i_ready
);
    localparam logic [3:0] LAST_PTR = 4'(16 - LANES);
    localparam logic [3:0] STEP     = 4'(LANES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic [23:0] r_pal [16];
    logic [23:0] r_pix;
    logic [3:0]  r_ptr;
    logic [3:0]  r_best_idx;
    logic [9:0]  r_best_dist;
    logic [3:0]  r_index;
    logic [9:0]  r_dist;
    logic        r_pal_err;
    logic        w_accept;
    logic        w_key;
    logic        w_last;
    logic [3:0]  w_idx_n;
    logic [9:0]  w_dist_n;
    logic [9:0]  w_lane_d [LANES];

    function automatic logic [7:0] f_absdiff(
        input logic [7:0] a,
        input logic [7:0] b
    );
        return (a > b) ? a - b : b - a;
    endfunction

    function automatic logic [9:0] f_dist(
        input logic [23:0] a,
        input logic [23:0] b
    );
        return 10'(f_absdiff(a[23:16], b[23:16]))
             + 10'(f_absdiff(a[15:8], b[15:8]))
             + 10'(f_absdiff(a[7:0], b[7:0]));
    endfunction

    assign w_accept  = i_valid && (r_state == S_IDLE);
    assign w_key     = (i_rgb == TRANSPARENT_KEY);
    assign o_ready   = (r_state == S_IDLE);
    assign o_valid   = (r_state == S_DONE);
    assign o_index   = r_index;
    assign o_dist    = r_dist;
    assign o_pal_err = r_pal_err;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_lane_d[l] = f_dist(r_pal[r_ptr + 4'(l)], r_pix);
        end
    end

    // Lanes are scanned in ascending order with strict '<', so ties keep
    // the lowest index both within a group and across groups.
    always_comb begin
        w_idx_n  = r_best_idx;
        w_dist_n = r_best_dist;
        for (int l = 0; l < LANES; l++) begin
            if (w_lane_d[l] < w_dist_n) begin
                w_dist_n = w_lane_d[l];
                w_idx_n  = r_ptr + 4'(l);
            end
        end
    end

    assign w_last = (r_ptr == LAST_PTR) || (w_dist_n == 10'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_n = w_key ? S_DONE : S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (w_last) begin
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (i_ready) begin
                    w_state_n = S_IDLE;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 16; k++) begin
                r_pal[k] <= 24'h0;
            end
            r_pix       <= 24'h0;
            r_ptr       <= 4'd1;
            r_best_idx  <= 4'd1;
            r_best_dist <= 10'h3FF;
            r_index     <= 4'd0;
            r_dist      <= 10'd0;
            r_pal_err   <= 1'b0;
        end else begin
            r_pal_err <= i_pal_we && (r_state != S_IDLE);
            if (i_pal_we && (r_state == S_IDLE)) begin
                r_pal[i_pal_addr] <= i_pal_data;
            end
            if (w_accept) begin
                r_pix       <= i_rgb;
                r_ptr       <= 4'd1;
                r_best_idx  <= 4'd1;
                r_best_dist <= 10'h3FF;
                if (w_key) begin
                    r_index <= 4'd0;
                    r_dist  <= 10'd0;
                end
            end else if (r_state == S_SEARCH) begin
                r_ptr       <= r_ptr + STEP;
                r_best_idx  <= w_idx_n;
                r_best_dist <= w_dist_n;
                if (w_last) begin
                    r_index <= w_idx_n;
                    r_dist  <= w_dist_n;
                end
            end
        end
    end
endmodule

// File: tb/tb_palette_encoder.sv
// tb_palette_encoder: three encoders (LANES 1, 5, 15) run on shared stimulus
// and are checked against a nearest-colour reference model.
`timescale 1ns/1ps
module tb_palette_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_addr = 4'd0;
    logic [23:0] pal_data = 24'h0;
    logic        in_valid = 1'b0;
    logic [23:0] in_rgb = 24'h0;
    logic        out_ready = 1'b0;
    logic [2:0]  err;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [3:0]  idx [3];
    logic [9:0]  dst [3];

    int          checks = 0;
    int          errors = 0;
    logic [23:0] pal_m [16];
    int          lanes_of [3] = '{1, 5, 15};
    int          lat [3];
    bit          to;
    logic [2:0]  rdy_acc;
    logic [2:0]  err_a;
    logic [2:0]  err_b;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        palette_encoder #(
            .LANES(g == 0 ? 1 : (g == 1 ? 5 : 15)),
            .TRANSPARENT_KEY(24'h000000)
        ) u_dut (
            .i_clk(clk),
            .i_rst_n(rst_n),
            .i_pal_we(pal_we),
            .i_pal_addr(pal_addr),
            .i_pal_data(pal_data),
            .o_pal_err(err[g]),
            .i_valid(in_valid),
            .i_rgb(in_rgb),
            .o_ready(rdy[g]),
            .o_valid(vld[g]),
            .o_index(idx[g]),
            .o_dist(dst[g]),
            .i_ready(out_ready)
        );
    end

    function automatic int cdist(input logic [23:0] a, input logic [23:0] b);
        int s;
        s = 0;
        for (int c = 0; c < 3; c++) begin
            int x;
            x = int'(a[c*8 +: 8]) - int'(b[c*8 +: 8]);
            s += (x < 0) ? -x : x;
        end
        return s;
    endfunction

    function automatic void model(input logic [23:0] rgb, input int lanes,
                                  output int ei, output int ed, output int el);
        ei = 0;
        ed = 0;
        el = 1;
        if (rgb == 24'h0) return;
        ed = 1 << 30;
        ei = 1;
        for (int k = 1; k < 16; k++) begin
            if (cdist(pal_m[k], rgb) < ed) begin
                ed = cdist(pal_m[k], rgb);
                ei = k;
            end
        end
        el = (ed == 0) ? (ei - 1) / lanes + 2 : 15 / lanes + 1;
    endfunction

    task automatic wr(input int a, input logic [23:0] d);
        @(negedge clk);
        pal_we   = 1'b1;
        pal_addr = 4'(a);
        pal_data = d;
        @(negedge clk);
        pal_we   = 1'b0;
        pal_m[a] = d;
    endtask

    task automatic run_pixel(input logic [23:0] rgb, input bit busy_wr,
                             input logic [23:0] busy_data);
        int         cnt;
        logic [2:0] done;
        @(negedge clk);
        rdy_acc  = rdy;
        in_valid = 1'b1;
        in_rgb   = rgb;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_rgb   = $urandom;
        cnt  = 1;
        done = 3'b000;
        to   = 1'b0;
        err_a = 3'bxxx;
        err_b = 3'bxxx;
        forever begin
            for (int d = 0; d < 3; d++) begin
                if (!done[d] && vld[d]) begin
                    done[d] = 1'b1;
                    lat[d]  = cnt;
                end
            end
            if (busy_wr) begin
                if (cnt == 1) begin
                    pal_we   = 1'b1;
                    pal_addr = 4'd4;
                    pal_data = busy_data;
                end
                if (cnt == 2) begin
                    pal_we = 1'b0;
                    err_a  = err;
                end
                if (cnt == 3) err_b = err;
            end
            if (done == 3'b111 && (!busy_wr || cnt >= 3)) break;
            if (cnt >= 40) begin
                to = 1'b1;
                break;
            end
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdy !== 3'b111 || vld !== 3'b000 || err !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold rdy=%b vld=%b err=%b want 111/000/000",
                     rdy, vld, err);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) pal_m[k] = 24'h0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (idx[d] !== 4'd0 || dst[d] !== 10'd0 || rdy[d] !== 1'b1
                || vld[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out lanes=%0d idx=%0d dist=%0d rdy=%b vld=%b",
                         lanes_of[d], idx[d], dst[d], rdy[d], vld[d]);
            end
        end
    endtask

    task automatic test_exact_match();
        int ei, ed, el;
        wr(1, 24'hacf52a);
        wr(11, 24'hdf52ff);
        wr(15, 24'h478438);
        run_pixel(24'hdf52ff, 1'b0, 24'h0);
        checks++;
        if (to || rdy_acc !== 3'b111 || lat[0] != 12) begin
            errors++;
            $display("FAIL exact_lat1 to=%0d rdy=%b lat=%0d want 12", to, rdy_acc, lat[0]);
        end
        for (int d = 0; d < 3; d++) begin
            model(24'hdf52ff, lanes_of[d], ei, ed, el);
            checks++;
            if (idx[d] !== 4'(ei) || dst[d] !== 10'(ed) || lat[d] != el) begin
                errors++;
                $display("FAIL exact lanes=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         lanes_of[d], idx[d], dst[d], lat[d], ei, ed, el);
            end
        end
        release_result();
        checks++;
        if (vld !== 3'b000 || rdy !== 3'b111) begin
            errors++;
            $display("FAIL exact_release vld=%b rdy=%b want 000/111", vld, rdy);
        end
    endtask

    task automatic test_transparent();
        run_pixel(24'h000000, 1'b0, 24'h0);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (to || idx[d] !== 4'd0 || dst[d] !== 10'd0 || lat[d] != 1) begin
                errors++;
                $display("FAIL transparent lanes=%0d got %0d/%0d/%0d want 0/0/1",
                         lanes_of[d], idx[d], dst[d], lat[d]);
            end
        end
        release_result();
    endtask

    task automatic test_tie();
        int ei, ed, el;
        wr(2, 24'h100000);
        wr(3, 24'h100000);
        run_pixel(24'h110000, 1'b0, 24'h0);
        for (int d = 0; d < 3; d++) begin
            model(24'h110000, lanes_of[d], ei, ed, el);
            checks++;
            if (to || idx[d] !== 4'd2 || dst[d] !== 10'd1 || lat[d] != el) begin
                errors++;
                $display("FAIL tie lanes=%0d got %0d/%0d/%0d want 2/1/%0d",
                         lanes_of[d], idx[d], dst[d], lat[d], el);
            end
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int ei, ed, el;
        run_pixel(24'h488538, 1'b0, 24'h0);
        for (int h = 0; h < 5; h++) begin
            for (int d = 0; d < 3; d++) begin
                model(24'h488538, lanes_of[d], ei, ed, el);
                checks++;
                if (to || vld[d] !== 1'b1 || rdy[d] !== 1'b0
                    || idx[d] !== 4'(ei) || dst[d] !== 10'(ed)) begin
                    errors++;
                    $display("FAIL hold%0d lanes=%0d vld=%b rdy=%b got %0d/%0d want %0d/%0d",
                             h, lanes_of[d], vld[d], rdy[d], idx[d], dst[d], ei, ed);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        release_result();
        checks++;
        if (vld !== 3'b000 || rdy !== 3'b111 || idx[0] !== 4'd15) begin
            errors++;
            $display("FAIL hold_release vld=%b rdy=%b idx=%0d want 000/111/15",
                     vld, rdy, idx[0]);
        end
    endtask

    task automatic test_pal_busy();
        int ei, ed, el;
        wr(4, 24'h3c5a7e);
        run_pixel(24'h808080, 1'b1, 24'h123456);
        checks++;
        if (to || err_a !== 3'b111 || err_b !== 3'b000) begin
            errors++;
            $display("FAIL pal_err pulse got %b then %b want 111 then 000", err_a, err_b);
        end
        release_result();
        run_pixel(24'h3c5a7e, 1'b0, 24'h0);
        for (int d = 0; d < 3; d++) begin
            model(24'h3c5a7e, lanes_of[d], ei, ed, el);
            checks++;
            if (to || idx[d] !== 4'd4 || dst[d] !== 10'(ed) || lat[d] != el) begin
                errors++;
                $display("FAIL pal_keep lanes=%0d got %0d/%0d/%0d want 4/%0d/%0d",
                         lanes_of[d], idx[d], dst[d], lat[d], ed, el);
            end
        end
        release_result();
    endtask

    task automatic test_reset_mid();
        int ei, ed, el;
        @(negedge clk);
        in_valid = 1'b1;
        in_rgb   = 24'h7f7f01;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (vld !== 3'b000 || rdy !== 3'b111) begin
            errors++;
            $display("FAIL mid_reset vld=%b rdy=%b want 000/111", vld, rdy);
        end
        for (int k = 0; k < 16; k++) pal_m[k] = 24'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (vld !== 3'b000 || rdy !== 3'b111 || idx[0] !== 4'd0) begin
            errors++;
            $display("FAIL mid_release vld=%b rdy=%b idx=%0d", vld, rdy, idx[0]);
        end
        for (int k = 1; k < 16; k++) wr(k, 24'($urandom));
        run_pixel(24'h7f7f01, 1'b0, 24'h0);
        for (int d = 0; d < 3; d++) begin
            model(24'h7f7f01, lanes_of[d], ei, ed, el);
            checks++;
            if (to || idx[d] !== 4'(ei) || dst[d] !== 10'(ed) || lat[d] != el) begin
                errors++;
                $display("FAIL resend lanes=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                         lanes_of[d], idx[d], dst[d], lat[d], ei, ed, el);
            end
        end
        release_result();
    endtask

    task automatic test_random();
        int          ei, ed, el, hold, sel;
        logic [23:0] px;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) wr(k, 24'($urandom));
            for (int p = 0; p < 8; p++) begin
                sel = $urandom_range(0, 3);
                if (sel == 0) px = 24'h0;
                else if (sel == 1) px = pal_m[$urandom_range(1, 15)];
                else px = 24'($urandom);
                run_pixel(px, 1'b0, 24'h0);
                hold = $urandom_range(0, 2);
                for (int h = 0; h <= hold; h++) begin
                    for (int d = 0; d < 3; d++) begin
                        model(px, lanes_of[d], ei, ed, el);
                        checks++;
                        if (to || vld[d] !== 1'b1 || idx[d] !== 4'(ei)
                            || dst[d] !== 10'(ed) || lat[d] != el) begin
                            errors++;
                            $display("FAIL rand px=%h lanes=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                                     px, lanes_of[d], idx[d], dst[d], lat[d], ei, ed, el);
                        end
                    end
                    if (h < hold) begin
                        @(posedge clk);
                        @(negedge clk);
                    end
                end
                release_result();
                checks++;
                if (vld !== 3'b000 || rdy !== 3'b111) begin
                    errors++;
                    $display("FAIL rand_release vld=%b rdy=%b want 000/111", vld, rdy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_match();
        test_transparent();
        test_tie();
        test_backpressure();
        test_pal_busy();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
